// File: rtl/axil_arith_unit_if.sv
// AXI4-Lite bundle for the arithmetic peripheral: five channels grouped with
// master/slave views so the bench and the slave share one declaration.
interface axil_arith_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 2
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [RESP_WIDTH-1:0]   bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [RESP_WIDTH-1:0]   rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_arith_unit.sv
// AXI4-Lite add/subtract peripheral: operand/control/result register bank
// plus a start/busy/done sequencer with a programmable compute latency.
module axil_arith_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 2,
  parameter int LATENCY    = 1
) (
  input  logic             s1_axi_aclk,
  input  logic             s1_axi_aresetn,
  axil_arith_unit_if.slave s1_axi,
  output logic             irq
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SHIFT  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - SHIFT;
  localparam int MSB    = DATA_WIDTH - 1;
  localparam logic [IDX_W-1:0] I_OPA = IDX_W'(0);
  localparam logic [IDX_W-1:0] I_OPB = IDX_W'(1);
  localparam logic [IDX_W-1:0] I_CTL = IDX_W'(2);
  localparam logic [IDX_W-1:0] I_RES = IDX_W'(3);
  localparam logic [IDX_W-1:0] I_STA = IDX_W'(4);
  localparam logic [RESP_WIDTH-1:0] OKAY   = '0;
  localparam logic [RESP_WIDTH-1:0] SLVERR = RESP_WIDTH'(2);

  typedef enum logic {IDLE, RUN} state_t;

  logic                  ready_en, aw_full, w_full, bvalid, rvalid;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data, rdata;
  logic [STRB_W-1:0]     w_strb;
  logic [RESP_WIDTH-1:0] bresp, rresp;
  logic [DATA_WIDTH-1:0] opa, opb, ctrl, result, snap_a, snap_b;
  logic                  snap_op, done, carry, ovf, busy, finish;
  logic [3:0]            cnt;
  state_t                state, state_nx;
  logic [IDX_W-1:0]      w_idx, r_idx;
  logic                  commit, w_err, start_req, start_go, r_err;
  logic [DATA_WIDTH-1:0] rd_val, status;

  function automatic logic [DATA_WIDTH-1:0] merge_strb(input logic [DATA_WIDTH-1:0] old_v,
                                                       input logic [DATA_WIDTH-1:0] new_v,
                                                       input logic [STRB_W-1:0] strb);
    logic [DATA_WIDTH-1:0] m;
    for (int i = 0; i < STRB_W; i++) m[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return m;
  endfunction

  // Returns {signed overflow, carry/borrow, result}; one extra bit catches carry-out.
  function automatic logic [DATA_WIDTH+1:0] arith(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b,
                                                  input logic sub);
    logic        [DATA_WIDTH:0]   wide;
    logic signed [DATA_WIDTH-1:0] sa, sb, sr;
    logic                         v;
    wide = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    sa = a;
    sb = b;
    sr = wide[DATA_WIDTH-1:0];
    v = ((sa[MSB] ^ sb[MSB]) == sub) && (sr[MSB] != sa[MSB]);
    return {v, wide[DATA_WIDTH], wide[DATA_WIDTH-1:0]};
  endfunction

  assign s1_axi.awready = ready_en && !aw_full && !bvalid;
  assign s1_axi.wready  = ready_en && !w_full && !bvalid;
  assign s1_axi.arready = ready_en && !rvalid;
  assign s1_axi.bvalid  = bvalid;
  assign s1_axi.bresp   = bresp;
  assign s1_axi.rvalid  = rvalid;
  assign s1_axi.rresp   = rresp;
  assign s1_axi.rdata   = rdata;
  assign irq    = done && ctrl[2];
  assign status = {{(DATA_WIDTH-4){1'b0}}, ovf, carry, done, busy};

  always_comb begin
    commit    = aw_full && w_full && !bvalid;
    w_idx     = aw_addr[ADDR_WIDTH-1:SHIFT];
    start_req = (w_idx == I_CTL) && w_strb[0] && w_data[0];
    w_err     = (|aw_addr[SHIFT-1:0]) || (w_idx > I_CTL) || (start_req && busy);
    start_go  = commit && !w_err && start_req;
  end

  // Write channel: independent AW/W buffers, commit once both are full.
  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      ready_en <= 1'b0;
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      aw_addr  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid   <= 1'b0;
      bresp    <= OKAY;
    end else begin
      ready_en <= 1'b1;
      if (s1_axi.awvalid && s1_axi.awready) begin
        aw_full <= 1'b1;
        aw_addr <= s1_axi.awaddr;
      end
      if (s1_axi.wvalid && s1_axi.wready) begin
        w_full <= 1'b1;
        w_data <= s1_axi.wdata;
        w_strb <= s1_axi.wstrb;
      end
      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= w_err ? SLVERR : OKAY;
      end
      if (bvalid && s1_axi.bready) begin
        bvalid  <= 1'b0;
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end
    end
  end

  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      opa  <= '0;
      opb  <= '0;
      ctrl <= '0;
    end else if (commit && !w_err) begin
      if (w_idx == I_OPA) opa <= merge_strb(opa, w_data, w_strb);
      if (w_idx == I_OPB) opb <= merge_strb(opb, w_data, w_strb);
      if (w_idx == I_CTL) ctrl <= merge_strb(ctrl, w_data, w_strb) & ~DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) state <= IDLE;
    else                 state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_go) state_nx = RUN;
      RUN:     if (finish) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == RUN);
    finish = (state == RUN) && (cnt == 4'd1);
  end

  // Operands are snapshotted so later OPA/OPB writes cannot disturb a run.
  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      snap_a  <= '0;
      snap_b  <= '0;
      snap_op <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      carry   <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else if (start_go) begin
      snap_a  <= opa;
      snap_b  <= opb;
      snap_op <= w_data[1];
      cnt     <= 4'(LATENCY);
      done    <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - 4'd1;
      if (finish) begin
        {ovf, carry, result} <= arith(snap_a, snap_b, snap_op);
        done <= 1'b1;
      end
    end
  end

  always_comb begin
    r_idx  = s1_axi.araddr[ADDR_WIDTH-1:SHIFT];
    r_err  = (|s1_axi.araddr[SHIFT-1:0]) || (r_idx > I_STA);
    rd_val = '0;
    if (!r_err) begin
      case (r_idx)
        I_OPA:   rd_val = opa;
        I_OPB:   rd_val = opb;
        I_CTL:   rd_val = ctrl;
        I_RES:   rd_val = result;
        default: rd_val = status;
      endcase
    end
  end

  // Read channel: data captured from pre-edge state at the AR handshake.
  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= OKAY;
    end else if (s1_axi.arvalid && s1_axi.arready) begin
      rvalid <= 1'b1;
      rdata  <= rd_val;
      rresp  <= r_err ? SLVERR : OKAY;
    end else if (rvalid && s1_axi.rready) begin
      rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axil_arith_unit.sv
// Bench for axil_arith_unit: directed register/handshake steps plus random
// add/sub operations checked against an arithmetic reference model.
module tb_axil_arith_unit;
  localparam int LAT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;
  int   checks = 0;
  int   errors = 0;
  logic m_carry = 1'b0;
  logic m_ovf = 1'b0;

  axil_arith_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(2)) bus ();

  axil_arith_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(2), .LATENCY(LAT)) dut (
    .s1_axi_aclk   (clk),
    .s1_axi_aresetn(rst_n),
    .s1_axi        (bus.slave),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: unbounded integer arithmetic, then range tests for carry/overflow.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit sub,
                                output logic [31:0] r, output bit c, output bit v);
    longint ua, ub, sa, sb, t, st;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    if (sub) begin
      t  = ua - ub;
      st = sa - sb;
      c  = (ua < ub);
    end else begin
      t  = ua + ub;
      st = sa + sb;
      c  = (t > 64'sh0FFFF_FFFF);
    end
    r = t[31:0];
    v = (st > 64'sd2147483647) || (st < -64'sd2147483648);
  endfunction

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    bit aw_ok, w_ok;
    n = 0;
    @(negedge clk);
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    while ((bus.awvalid || bus.wvalid) && n < 50) begin
      aw_ok = bus.awvalid && bus.awready;
      w_ok  = bus.wvalid && bus.wready;
      @(negedge clk);
      n++;
      if (aw_ok) bus.awvalid = 1'b0;
      if (w_ok) bus.wvalid = 1'b0;
    end
    while (!bus.bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wr_timeout", 32'(n < 50), 32'd1);
    resp = bus.bresp;
    @(negedge clk);
    bus.bready = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    bit ar_ok;
    n = 0;
    @(negedge clk);
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
    while (bus.arvalid && n < 50) begin
      ar_ok = bus.arready;
      @(negedge clk);
      n++;
      if (ar_ok) bus.arvalid = 1'b0;
    end
    while (!bus.rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rd_timeout", 32'(n < 50), 32'd1);
    data = bus.rdata;
    resp = bus.rresp;
    @(negedge clk);
    bus.rready = 1'b0;
    bus.arvalid = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit sub,
                        input bit ie, input string tag);
    logic [31:0] d, er;
    logic [1:0]  rs;
    bit          ec, ev;
    model(a, b, sub, er, ec, ev);
    axi_write(8'h00, a, 4'hF, rs);
    check({tag, "_wr_opa"}, 32'(rs), 32'd0);
    axi_write(8'h04, b, 4'hF, rs);
    check({tag, "_wr_opb"}, 32'(rs), 32'd0);
    axi_write(8'h08, {29'd0, ie, sub, 1'b1}, 4'h1, rs);
    check({tag, "_wr_ctrl"}, 32'(rs), 32'd0);
    axi_read(8'h10, d, rs);
    check({tag, "_busy"}, d, {28'd0, m_ovf, m_carry, 2'b01});
    cycles(LAT + 2);
    axi_read(8'h0C, d, rs);
    check({tag, "_result"}, d, er);
    axi_read(8'h10, d, rs);
    check({tag, "_status"}, d, {28'd0, ev, ec, 2'b10});
    check({tag, "_irq"}, 32'(irq), 32'(ie));
    m_carry = ec;
    m_ovf = ev;
  endtask

  initial begin
    logic [31:0] d, ra, rb;
    logic [1:0]  rs;
    bit          rsub, rie;

    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset defaults
    repeat (3) @(negedge clk);
    check("rst_outputs", {24'd0, bus.awready, bus.wready, bus.arready, bus.bvalid,
                          bus.rvalid, irq, |bus.bresp, |bus.rresp}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      axi_read(8'(i * 4), d, rs);
      check($sformatf("rst_reg%0d", i), d, 32'd0);
      check($sformatf("rst_resp%0d", i), 32'(rs), 32'd0);
    end
    check("rst_irq", 32'(irq), 32'd0);

    // Add with signed overflow, interrupt enabled
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, "addovf");
    axi_read(8'h0C, d, rs);
    check("addovf_result_const", d, 32'h8000_0000);
    axi_read(8'h10, d, rs);
    check("addovf_status_const", d, 32'h0000_000A);
    axi_read(8'h08, d, rs);
    check("ctrl_readback", d, 32'h0000_0004);

    // Subtract with borrow
    run_op(32'd5, 32'd7, 1'b1, 1'b0, "subbrw");
    axi_read(8'h0C, d, rs);
    check("subbrw_result_const", d, 32'hFFFF_FFFE);
    axi_read(8'h10, d, rs);
    check("subbrw_status_const", d, 32'h0000_0006);

    // Error responses
    axi_read(8'h18, d, rs);
    check("rd_0x18_resp", 32'(rs), 32'd2);
    check("rd_0x18_data", d, 32'd0);
    axi_read(8'h01, d, rs);
    check("rd_misal_resp", 32'(rs), 32'd2);
    axi_write(8'h0C, 32'h1234_5678, 4'hF, rs);
    check("wr_result_resp", 32'(rs), 32'd2);
    axi_write(8'h10, 32'h0000_00FF, 4'hF, rs);
    check("wr_status_resp", 32'(rs), 32'd2);
    axi_read(8'h10, d, rs);
    check("status_after_err", d, 32'h0000_0006);

    // Start while busy is refused; operand writes during a run do not leak in
    axi_write(8'h00, 32'd10, 4'hF, rs);
    axi_write(8'h04, 32'd20, 4'hF, rs);
    axi_write(8'h08, 32'h1, 4'h1, rs);
    check("busy_first_start", 32'(rs), 32'd0);
    axi_write(8'h08, 32'h3, 4'h1, rs);
    check("busy_start_resp", 32'(rs), 32'd2);
    axi_write(8'h00, 32'h100, 4'hF, rs);
    check("busy_opa_resp", 32'(rs), 32'd0);
    cycles(LAT + 2);
    axi_read(8'h0C, d, rs);
    check("busy_result", d, 32'd30);
    axi_read(8'h10, d, rs);
    check("busy_status", d, 32'h0000_0002);
    axi_read(8'h00, d, rs);
    check("busy_opa_new", d, 32'h100);
    m_carry = 1'b0;
    m_ovf = 1'b0;

    // W three cycles ahead of AW, then a stalled B channel
    @(negedge clk);
    bus.wdata = 32'hCAFE_0001; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b0;
    check("ord_wready", 32'(bus.wready), 32'd1);
    @(negedge clk);
    bus.wvalid = 1'b0;
    check("ord_wready_full", 32'(bus.wready), 32'd0);
    cycles(2);
    check("ord_awready", 32'(bus.awready), 32'd1);
    bus.awaddr = 8'h04; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ord_hold%0d", i), {29'd0, bus.bvalid, bus.awready, bus.wready}, 32'b100);
      @(negedge clk);
    end
    check("ord_bresp", 32'(bus.bresp), 32'd0);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("ord_release", {29'd0, bus.bvalid, bus.awready, bus.wready}, 32'b011);
    axi_read(8'h04, d, rs);
    check("ord_opb", d, 32'hCAFE_0001);

    // Byte strobes; a start without strobe byte 0 does nothing
    axi_write(8'h00, 32'hFFFF_FFFF, 4'hF, rs);
    axi_write(8'h00, 32'h1234_5678, 4'h3, rs);
    axi_read(8'h00, d, rs);
    check("strb_opa", d, 32'hFFFF_5678);
    axi_write(8'h08, 32'h0000_0001, 4'h2, rs);
    check("strb_ctrl_resp", 32'(rs), 32'd0);
    cycles(2);
    axi_read(8'h10, d, rs);
    check("strb_no_start", d, 32'h0000_0002);

    // Random operations against the model
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'h8000_0000;
      if (i == 1) rb = 32'hFFFF_FFFF;
      rsub = 1'($urandom_range(0, 1));
      rie  = 1'($urandom_range(0, 1));
      run_op(ra, rb, rsub, rie, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset drops irq without waiting for a clock edge
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, "pre_rst");
    check("pre_rst_irq_high", 32'(irq), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-run aborts without producing done
    axi_write(8'h00, 32'd3, 4'hF, rs);
    axi_write(8'h04, 32'd4, 4'hF, rs);
    axi_write(8'h08, 32'h5, 4'h1, rs);
    cycles(3);
    #2 rst_n = 1'b0;
    #1 check("abort_irq", 32'(irq), 32'd0);
    repeat (LAT + 2) @(negedge clk);
    rst_n = 1'b1;
    cycles(LAT + 2);
    axi_read(8'h10, d, rs);
    check("abort_status", d, 32'd0);
    axi_read(8'h0C, d, rs);
    check("abort_result", d, 32'd0);
    axi_read(8'h00, d, rs);
    check("abort_opa", d, 32'd0);
    check("abort_irq_after", 32'(irq), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
